// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - alu_op_e : 3-bit ALU opcodes as driven by the ALU controller.
//   - state_e  : seq_alu FSM state encoding (also visible on state_dbg).
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD      = 3'd0,
        ALU_SUB      = 3'd1,
        ALU_AND      = 3'd2,
        ALU_OR       = 3'd3,
        ALU_SLT      = 3'd4,
        ALU_MULU     = 3'd5,
        ALU_DIVU     = 3'd6,
        ALU_DEACTIVE = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: iterative unsigned multiply / restoring divide datapath.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : latch operands a_i/b_i, clear accumulator, counter = WIDTH
//   step_i      : perform one iteration (one product or quotient bit)
//   is_div_i    : mode captured at load (1 = divide, 0 = multiply)
//   a_i, b_i    : multiplier/multiplicand or dividend/divisor
//   lo_nxt_o    : next value of the lo register (low product / quotient)
//   hi_nxt_o    : next value of the hi part (high product / remainder)
//   last_o      : the current step is the final one
// The *_nxt_o outputs let the parent register the final answer on the same
// edge that performs the last iteration.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_nxt_o,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc_q: multiply upper half (bit WIDTH unused, kept 0) or the
    // WIDTH+1-bit remainder. lo_q: multiplier shifting out while product
    // bits shift in, or dividend shifting out while quotient bits shift in.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        acc_d  = acc_q;
        lo_d   = lo_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (load_i) begin
            acc_d  = '0;
            lo_d   = a_i;
            opb_d  = b_i;
            cnt_d  = CNT_W'(WIDTH);
            mode_d = is_div_i;
        end else if (step_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (mode_q) begin
                // Trial subtract one bit wider than the remainder so the
                // borrow lands in the MSB.
                rem_sh = {acc_q, lo_q[WIDTH-1]};
                diff   = rem_sh - {2'b00, opb_q};
                if (diff[WIDTH+1]) begin
                    acc_d = rem_sh[WIDTH:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = diff[WIDTH:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                // Conditional add into the upper half, then shift
                // {carry,hi,lo} right by one.
                sum   = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
                acc_d = {1'b0, sum[WIDTH:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign lo_nxt_o = lo_d;
    assign hi_nxt_o = acc_d[WIDTH-1:0];
    assign last_o   = step_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle add/sub/and/or/slt/deactive and
// iterative unsigned multiply/divide behind a start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, sampled only in IDLE
//   op         : 3-bit opcode (alu_op_e)
//   a, b       : operands (dividend / divisor for divu)
//   result     : low product / quotient / single-cycle result
//   hi         : high product / remainder; 0 for single-cycle ops
//   zero       : registered (result == 0)
//   div0       : divu issued with b == 0
//   busy       : multi-cycle operation in progress
//   done       : one-cycle pulse, outputs valid
//   state_dbg  : current FSM state (state_e encoding)
// Handshake: a request is accepted on a rising edge where start=1 and the FSM
// is in IDLE; start in RUN or DONE is dropped. done pulses for exactly one
// cycle, after which result/hi/zero/div0 hold until the next acceptance.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div0,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    import seq_alu_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] alu_res;
    logic             core_load;
    logic             core_step;
    logic             core_last;
    logic [WIDTH-1:0] core_lo_nxt;
    logic [WIDTH-1:0] core_hi_nxt;

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (op == ALU_DIVU),
        .a_i      (a),
        .b_i      (b),
        .lo_nxt_o (core_lo_nxt),
        .hi_nxt_o (core_hi_nxt),
        .last_o   (core_last)
    );

    // Single-cycle ALU.
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a + ~b + WIDTH'(1);
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        div0_d    = div0_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div0_d = 1'b0;
                    if (op == ALU_MULU || (op == ALU_DIVU && b != '0)) begin
                        core_load = 1'b1;
                        state_d   = S_RUN;
                    end else if (op == ALU_DIVU) begin
                        result_d = '1;
                        hi_d     = a;
                        zero_d   = 1'b0;
                        div0_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        result_d = alu_res;
                        hi_d     = '0;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                core_step = 1'b1;
                if (core_last) begin
                    result_d = core_lo_nxt;
                    hi_d     = core_hi_nxt;
                    zero_d   = (core_lo_nxt == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            div0_q   <= div0_d;
        end
    end

    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign div0      = div0_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu at WIDTH=32 and WIDTH=8.
// Drivers push expected responses into per-DUT queues; monitors pop and
// compare on every done pulse, including latency and busy-cycle count.
module tb_seq_alu;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        div0;
        int          t0;
        int          lat;
        int          bsy;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // DUT 32
    logic        start32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] res32, hi32;
    logic        zero32, div032, busy32, done32;
    logic [1:0]  st32;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .result(res32), .hi(hi32), .zero(zero32), .div0(div032),
        .busy(busy32), .done(done32), .state_dbg(st32)
    );

    // DUT 8
    logic       start8 = 1'b0;
    logic [2:0] op8 = 3'd0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] res8, hi8;
    logic       zero8, div08, busy8, done8;
    logic [1:0] st8;

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(res8), .hi(hi8), .zero(zero8), .div0(div08),
        .busy(busy8), .done(done8), .state_dbg(st8)
    );

    // scoreboard
    exp_t exp32_q[$];
    exp_t exp8_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    int bsy32_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) bsy32_cnt = 0;
        else begin
            if (busy32) bsy32_cnt++;
            if (done32) begin
                if (exp32_q.size() == 0) chk("w32_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp32_q.pop_front();
                    chk("w32_result", res32, e.res);
                    chk("w32_hi", hi32, e.hi);
                    chk("w32_zero", {31'd0, zero32}, {31'd0, e.zero});
                    chk("w32_div0", {31'd0, div032}, {31'd0, e.div0});
                    chk("w32_latency", cyc - e.t0, e.lat);
                    chk("w32_busy_cycles", bsy32_cnt, e.bsy);
                end
                bsy32_cnt = 0;
            end
        end
    end

    int bsy8_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) bsy8_cnt = 0;
        else begin
            if (busy8) bsy8_cnt++;
            if (done8) begin
                if (exp8_q.size() == 0) chk("w8_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp8_q.pop_front();
                    chk("w8_result", {24'd0, res8}, e.res);
                    chk("w8_hi", {24'd0, hi8}, e.hi);
                    chk("w8_zero", {31'd0, zero8}, {31'd0, e.zero});
                    chk("w8_div0", {31'd0, div08}, {31'd0, e.div0});
                    chk("w8_latency", cyc - e.t0, e.lat);
                    chk("w8_busy_cycles", bsy8_cnt, e.bsy);
                end
                bsy8_cnt = 0;
            end
        end
    end

    // drivers
    task automatic wait_idle32();
        int n = 0;
        while ((busy32 || done32) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("w32_idle_wait");
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((busy8 || done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("w8_idle_wait");
    endtask

    task automatic push32(input logic [31:0] r, input logic [31:0] h, input logic d0,
                          input int t0, input int lat, input int bsy);
        exp_t e;
        e.res = r; e.hi = h; e.zero = (r == 32'd0); e.div0 = d0;
        e.t0 = t0; e.lat = lat; e.bsy = bsy;
        exp32_q.push_back(e);
    endtask

    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [31:0] h, input logic d0,
                           input int lat, input int bsy);
        wait_idle32();
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        push32(r, h, d0, cyc, lat, bsy);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic [7:0] h, input logic d0,
                          input int lat, input int bsy);
        exp_t e;
        wait_idle8();
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        e.res = {24'd0, r}; e.hi = {24'd0, h}; e.zero = (r == 8'd0); e.div0 = d0;
        e.t0 = cyc; e.lat = lat; e.bsy = bsy;
        exp8_q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // main sequence
    initial begin
        int d;
        int n;
        #3;
        chk("reset_result", res32, 32'd0);
        chk("reset_hi", hi32, 32'd0);
        chk("reset_zero", {31'd0, zero32}, 32'd0);
        chk("reset_div0", {31'd0, div032}, 32'd0);
        chk("reset_busy", {31'd0, busy32}, 32'd0);
        chk("reset_done", {31'd0, done32}, 32'd0);
        chk("reset_state", {30'd0, st32}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single-cycle ops: op, a, b, result, hi, div0, latency, busy cycles
        issue32(3'd0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1, 0);
        issue32(3'd1, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1, 0);
        issue32(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1'b0, 1, 0);
        issue32(3'd3, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 32'd0, 1'b0, 1, 0);
        issue32(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1, 0);
        issue32(3'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1, 0);
        issue32(3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 1, 0);
        issue32(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, 1, 0);

        // mulu with start held every cycle and operands scrambled during RUN;
        // only the mulu and then one add on the first IDLE cycle are accepted.
        wait_idle32();
        d = cyc;
        start32 = 1'b1; op32 = 3'd5; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
        push32(32'hFFFF_FFFE, 32'd1, 1'b0, d, 33, 32);
        push32(32'd7, 32'd0, 1'b0, d + 34, 1, 0);
        @(negedge clk);
        op32 = 3'd0;
        while (cyc < d + 33) begin
            a32 = $urandom;
            b32 = $urandom;
            @(negedge clk);
        end
        a32 = 32'd3; b32 = 32'd4;
        @(negedge clk);
        @(negedge clk);
        start32 = 1'b0;

        issue32(3'd6, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32);
        issue32(3'd6, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
        issue32(3'd0, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1, 0);
        issue32(3'd5, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0, 33, 32);
        issue32(3'd6, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33, 32);

        // reset in the middle of a divu: nothing expected from it
        wait_idle32();
        start32 = 1'b1; op32 = 3'd6; a32 = 32'd100; b32 = 32'd7;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_busy_before_reset", {31'd0, busy32}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_result", res32, 32'd0);
        chk("midrun_reset_hi", hi32, 32'd0);
        chk("midrun_reset_zero", {31'd0, zero32}, 32'd0);
        chk("midrun_reset_div0", {31'd0, div032}, 32'd0);
        chk("midrun_reset_busy", {31'd0, busy32}, 32'd0);
        chk("midrun_reset_done", {31'd0, done32}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue32(3'd0, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, 1, 0);

        // WIDTH=8 instance
        issue8(3'd5, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 9, 8);
        issue8(3'd6, 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9, 8);
        issue8(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1, 0);
        issue8(3'd4, 8'h80, 8'h7F, 8'h01, 8'h00, 1'b0, 1, 0);
        issue8(3'd6, 8'h33, 8'h00, 8'hFF, 8'h33, 1'b1, 1, 0);

        n = 0;
        while ((exp32_q.size() != 0 || exp8_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp32_q.size() != 0) fail_now("w32_missing_done");
        if (exp8_q.size() != 0) fail_now("w8_missing_done");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
